// File: rtl/matrix_pkg.sv
// matrix_pkg: shared word width, loader states and element packing for the Cannon datapath
package matrix_pkg;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} loader_state_t;
  function automatic int word_index(input int row, input int col, input int n);
    return row + n * col;
  endfunction
endpackage

// File: rtl/matrix_stream_loader_if.sv
// matrix_stream_loader_if: word stream in, assembled A/B hand-off out
// checksum is present only when MATRIX_LOADER_CHECKSUM_EN is defined
interface matrix_stream_loader_if #(parameter int n = 4);
  import matrix_pkg::*;
  logic [WORD_W-1:0] in_data;
  logic in_valid;
  logic in_ready;
  logic in_last;
  logic [WORD_W*n*n-1:0] matrix_A;
  logic [WORD_W*n*n-1:0] matrix_B;
  logic mat_valid;
  logic mat_done;
  logic err;
`ifdef MATRIX_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] checksum;
  modport master (output in_data, in_valid, in_last, mat_done,
                  input in_ready, matrix_A, matrix_B, mat_valid, err, checksum);
  modport slave (input in_data, in_valid, in_last, mat_done,
                 output in_ready, matrix_A, matrix_B, mat_valid, err, checksum);
`else
  modport master (output in_data, in_valid, in_last, mat_done,
                  input in_ready, matrix_A, matrix_B, mat_valid, err);
  modport slave (input in_data, in_valid, in_last, mat_done,
                 output in_ready, matrix_A, matrix_B, mat_valid, err);
`endif
endinterface

// File: rtl/matrix_stream_loader_load_counter.sv
// load_counter: word index within one matrix, wraps at n*n-1 with a terminal flag
module load_counter #(
  parameter int n = 4,
  localparam int IW = n * n > 1 ? $clog2(n * n) : 1
) (
  input  logic          clk,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [IW-1:0] idx_o,
  output logic          term_o
);
  localparam logic [IW-1:0] LAST = IW'(n * n - 1);
  logic [IW-1:0] idx_q;
  always_ff @(posedge clk)
    idx_q <= clr_i || (en_i && term_o) ? '0 : en_i ? idx_q + 1'b1 : idx_q;
  assign idx_o  = idx_q;
  assign term_o = idx_q == LAST;
endmodule

// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader: assembles A then B from a word stream and holds them until mat_done
// optional frame checksum under MATRIX_LOADER_CHECKSUM_EN
module matrix_stream_loader
  import matrix_pkg::*;
#(
  parameter int n = 4
) (
  input logic clk,
  input logic reset,
  matrix_stream_loader_if.slave bus
);
  localparam int IW = n * n > 1 ? $clog2(n * n) : 1;
  loader_state_t state_q;
  logic [WORD_W*n*n-1:0] a_q, b_q;
  logic mv_q, err_q;
  logic [IW-1:0] idx;
  logic term, acc, last_ok, abort, rel;
  always_comb begin
    acc     = bus.in_valid && bus.in_ready;
    last_ok = state_q == LOAD_B && term;
    abort   = acc && bus.in_last && !last_ok;
    rel     = state_q == HOLD && bus.mat_done;
  end
  load_counter #(.n(n)) u_cnt (
    .clk   (clk),
    .clr_i (!reset || abort || rel),
    .en_i  (acc && !abort),
    .idx_o (idx),
    .term_o(term)
  );
  // an early in_last drops the word and restarts the frame; old A/B words are left in place
  always_ff @(posedge clk)
    if (!reset) begin
      state_q <= LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      mv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else if (abort) begin
      state_q <= LOAD_A;
      err_q   <= 1'b1;
    end else if (rel) begin
      state_q <= LOAD_A;
      mv_q    <= 1'b0;
    end else if (acc) begin
      if (state_q == LOAD_A) a_q[WORD_W*idx +: WORD_W] <= bus.in_data;
      else b_q[WORD_W*idx +: WORD_W] <= bus.in_data;
      if (term) state_q <= state_q == LOAD_A ? LOAD_B : HOLD;
      if (last_ok) begin
        mv_q  <= 1'b1;
        err_q <= err_q || !bus.in_last;
      end
    end
  assign bus.in_ready  = state_q != HOLD && reset;
  assign bus.matrix_A  = a_q;
  assign bus.matrix_B  = b_q;
  assign bus.mat_valid = mv_q;
  assign bus.err       = err_q;
`ifdef MATRIX_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] sum_q;
  always_ff @(posedge clk)
    if (!reset || abort) sum_q <= '0;
    else if (acc) sum_q <= state_q == LOAD_A && idx == '0 ? bus.in_data : sum_q + bus.in_data;
  assign bus.checksum = sum_q;
`endif
endmodule
